// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 adder pipeline.
// Build macro FPU_DENORM_EN selects gradual underflow; flush-to-zero otherwise.
package fpu_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned SIG_W   = FRAC_W + 1;
  localparam int unsigned DP_W    = SIG_W + 3;
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    fp_class_e        cls;
  } fp_op_t;

  typedef struct packed {
    logic             spec_vld;
    logic [31:0]      spec_val;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
    logic [EXP_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic             spec_vld;
    logic [31:0]      spec_val;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [DP_W:0]    sum;
  } s2_t;

  // Unpack and classify; subnormals either get exponent 1 or collapse to a signed zero.
  function automatic fp_op_t unpack_op(input logic [31:0] f);
    fp_op_t            o;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] m;
    e      = f[30:23];
    m      = f[22:0];
    o.sign = f[31];
    o.exp  = e;
    o.sig  = {1'b1, m};
    o.cls  = CLS_NORM;
    if (e == '1) begin
      o.cls = (m != '0) ? CLS_NAN : CLS_INF;
    end else if (e == '0) begin
      if (m == '0) begin
        o.cls = CLS_ZERO;
        o.sig = '0;
      end else begin
        o.cls = CLS_SUB;
`ifdef FPU_DENORM_EN
        o.exp = EXP_W'(1);
        o.sig = {1'b0, m};
`else
        o.sig = '0;
`endif
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/fpu_if.sv
// Operand/result bundle of the adder: two binary32 operands in, one sum out.
interface fpu_if;
  logic [31:0] F1;
  logic [31:0] F2;
  logic [31:0] F3;

  modport master (output F1, output F2, input F3);
  modport slave  (input F1, input F2, output F3);
endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter over the 27-bit significand datapath.
module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [DP_W-1:0] vec,
  output logic [4:0]      cnt_c
);

  // Scanning upward lets the highest set bit write last.
  always_comb begin
    cnt_c = 5'(DP_W);
    for (int i = 0; i < int'(DP_W); i++) begin
      if (vec[i]) cnt_c = 5'(int'(DP_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fpu.sv
// Three-stage binary32 adder: unpack/swap, align/add, normalize/round/pack.
// Build macro FPU_DENORM_EN enables subnormal inputs/outputs; otherwise flush-to-zero.
module fpu
  import fpu_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  fpu_if.slave  bus
);

  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [31:0] f3_d, f3_q;

  fp_op_t ua, ub, big, sml;
  logic   swap;

  // Stage 1: classify, order by magnitude, resolve NaN/infinity up front.
  always_comb begin
    ua   = unpack_op(bus.F1);
    ub   = unpack_op(bus.F2);
    swap = {ub.exp, ub.sig} > {ua.exp, ua.sig};
    big  = swap ? ub : ua;
    sml  = swap ? ua : ub;

    s1_d       = '0;
    s1_d.sign  = big.sign;
    s1_d.sub   = big.sign ^ sml.sign;
    s1_d.exp   = big.exp;
    s1_d.sig_a = big.sig;
    s1_d.sig_b = sml.sig;
    s1_d.diff  = big.exp - sml.exp;

    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN ||
        (ua.cls == CLS_INF && ub.cls == CLS_INF && ua.sign != ub.sign)) begin
      s1_d.spec_vld = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (ua.cls == CLS_INF) begin
      s1_d.spec_vld = 1'b1;
      s1_d.spec_val = ua.sign ? NEG_INF : POS_INF;
    end else if (ub.cls == CLS_INF) begin
      s1_d.spec_vld = 1'b1;
      s1_d.spec_val = ub.sign ? NEG_INF : POS_INF;
    end
  end

  logic [DP_W-1:0] a_ext, b_ext, b_al, lost;

  // Stage 2: align the smaller operand with guard/round/sticky, then add or subtract.
  always_comb begin
    a_ext = {s1_q.sig_a, 3'b000};
    b_ext = {s1_q.sig_b, 3'b000};
    lost  = '0;
    if (s1_q.diff >= EXP_W'(DP_W - 1)) begin
      b_al = {{(DP_W-1){1'b0}}, |s1_q.sig_b};
    end else begin
      b_al    = b_ext >> s1_q.diff[4:0];
      lost    = b_ext & ((DP_W'(1) << s1_q.diff[4:0]) - DP_W'(1));
      b_al[0] = b_al[0] | (|lost);
    end

    s2_d          = '0;
    s2_d.spec_vld = s1_q.spec_vld;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sign;
    s2_d.sub      = s1_q.sub;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = s1_q.sub ? ({1'b0, a_ext} - {1'b0, b_al})
                             : ({1'b0, a_ext} + {1'b0, b_al});
  end

  logic [4:0] lz_c;

  fpu_lzc u_lzc (
    .vec   (s2_q.sum[DP_W-1:0]),
    .cnt_c (lz_c)
  );

  logic [4:0]        shamt;
  logic [DP_W-1:0]   m;
  logic signed [9:0] exp_n, exp_f;
  logic              rnd_up;
  logic [SIG_W:0]    sig_r;
  logic [SIG_W-1:0]  sig_f;
  logic [EXP_W-1:0]  exp_field;

  // Stage 3: normalize, round to nearest-even, handle overflow/underflow and pack.
  always_comb begin
    shamt = '0;
    if (s2_q.sum[DP_W]) begin
      m     = {s2_q.sum[DP_W:2], |s2_q.sum[1:0]};
      exp_n = 10'(s2_q.exp) + 10'd1;
    end else begin
`ifdef FPU_DENORM_EN
      // Stop at exponent 1 so tiny results land in the subnormal encoding.
      if (10'(lz_c) >= 10'(s2_q.exp)) shamt = 5'(s2_q.exp - EXP_W'(1));
      else                            shamt = lz_c;
`else
      shamt = lz_c;
`endif
      m     = s2_q.sum[DP_W-1:0] << shamt;
      exp_n = 10'(s2_q.exp) - 10'(shamt);
    end

    rnd_up = m[2] & (m[3] | m[1] | m[0]);
    sig_r  = {1'b0, m[DP_W-1:3]} + (SIG_W+1)'(rnd_up);
    if (sig_r[SIG_W]) begin
      sig_f = sig_r[SIG_W:1];
      exp_f = exp_n + 10'sd1;
    end else begin
      sig_f = sig_r[SIG_W-1:0];
      exp_f = exp_n;
    end

`ifdef FPU_DENORM_EN
    exp_field = sig_f[SIG_W-1] ? exp_f[EXP_W-1:0] : '0;
`else
    exp_field = exp_f[EXP_W-1:0];
`endif
    f3_d = {s2_q.sign, exp_field, sig_f[FRAC_W-1:0]};

    if (s2_q.spec_vld) begin
      f3_d = s2_q.spec_val;
    end else if (s2_q.sum == '0) begin
      f3_d = {~s2_q.sub & s2_q.sign, 31'd0};
    end else if (exp_f >= $signed(10'(EXP_MAX))) begin
      f3_d = s2_q.sign ? NEG_INF : POS_INF;
`ifndef FPU_DENORM_EN
    end else if (exp_f <= 10'sd0 || !sig_f[SIG_W-1]) begin
      f3_d = {s2_q.sign, 31'd0};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      f3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      f3_q <= f3_d;
    end
  end

  assign bus.F3 = f3_q;

endmodule

// File: tb/tb_fpu.sv
// Directed and random checks of the binary32 adder against an exact-integer reference model.
module tb_fpu;

  logic clk = 1'b0;
  logic rst_n;

  fpu_if bus ();

  fpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: F3=%h expected %h", tag, obs, expv);
    end
  endtask

  // Magnitude scaled by 2^149 so every finite binary32 is an exact integer.
  function automatic logic [279:0] mag_of(input logic [31:0] f);
    logic [279:0] mg;
    mg = '0;
    if (f[30:23] == 8'd0) begin
`ifdef FPU_DENORM_EN
      mg = 280'(f[22:0]);
`endif
    end else begin
      mg = 280'({1'b1, f[22:0]});
      mg = mg << (f[30:23] - 8'd1);
    end
    return mg;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [279:0] ma, mb, mag, keep, rem, half, one;
    logic         s, nan_a, nan_b, inf_a, inf_b;
    int           p, sh;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) return 32'h7FC0_0000;
    if (inf_a) return a;
    if (inf_b) return b;
    ma = mag_of(a);
    mb = mag_of(b);
    if (a[31] == b[31]) begin
      mag = ma + mb; s = a[31];
    end else if (ma >= mb) begin
      mag = ma - mb; s = a[31];
    end else begin
      mag = mb - ma; s = b[31];
    end
    if (mag == '0) return {a[31] & b[31], 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p <= 23) begin
`ifndef FPU_DENORM_EN
      if (p < 23) return {s, 31'd0};
`endif
      return {s, mag[30:0]};
    end
    sh   = p - 23;
    one  = 280'd1;
    keep = mag >> sh;
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + one;
    if (keep[24]) begin
      keep = keep >> 1;
      sh++;
    end
    if (sh + 1 >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(sh + 1), keep[22:0]};
  endfunction

  // Drive one operation (with a junk value between edges), then compare the oldest result.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input string tag);
    bus.F1 = $urandom;
    bus.F2 = $urandom;
    #2;
    bus.F1 = a;
    bus.F2 = b;
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    check(tag_q.pop_front(), bus.F3, exp_q.pop_front());
  endtask

  task automatic prime_pipe();
    exp_q.delete();
    tag_q.delete();
    repeat (2) begin
      exp_q.push_back(32'd0);
      tag_q.push_back("empty_pipe");
    end
  endtask

  logic [31:0] ra, rb, tiny_exp;

  initial begin
    rst_n  = 1'b0;
    bus.F1 = 32'h3F80_0000;
    bus.F2 = 32'h3F80_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", bus.F3, 32'd0);
    rst_n = 1'b1;
    prime_pipe();

    step(32'h3F40_0000, 32'h3EE0_0000, 32'h3F98_0000, "add_0.75_0.4375");
    step(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "cancel_to_pos0");
    step(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    step(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
    step(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even");
    step(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "above_tie");
`ifdef FPU_DENORM_EN
    tiny_exp = 32'h0000_0002;
`else
    tiny_exp = 32'h0000_0000;
`endif
    step(32'h0000_0001, 32'h0000_0001, tiny_exp, "subnormal_sum");
    step(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "neg0_plus_neg0");
    step(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    step(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "neg_inf_in");
    step(32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, "neg_result");

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = ra ^ 32'h8000_0000;
        1, 2, 3: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
        4: ra[30:23] = 8'd0;
        5: rb[30:23] = 8'hFF;
        6: begin
          ra[30:23] = 8'($urandom_range(0, 3));
          rb[30:23] = 8'($urandom_range(0, 3));
        end
        7: begin
          ra[30:23] = 8'hFE;
          rb[30:23] = 8'hFE - 8'($urandom_range(0, 1));
        end
        default: ;
      endcase
      step(ra, rb, ref_add(ra, rb), $sformatf("rand %h+%h", ra, rb));
    end

    // Fill the pipeline with non-zero work, then reset between edges.
    repeat (3) step(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", bus.F3, 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", bus.F3, 32'd0);
    rst_n = 1'b1;
    prime_pipe();
    step(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, "post_reset_3+1");
    step(32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, "post_reset_-3+1");
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      step(ra, rb, ref_add(ra, rb), $sformatf("rand2 %h+%h", ra, rb));
    end
    repeat (2) step(32'd0, 32'd0, 32'd0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
